// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the producer handshake and the FIFO write-side signals that
// fifo_wr_arbiter sits between.
//   req_valid  [NREQ]        producer i has a beat to write
//   req_data   [NREQ*WIDTH]  producer i's beat on [i*WIDTH +: WIDTH]
//   req_ready  [NREQ]        producer i's beat is accepted this cycle
//   fifo_full                FIFO full flag
//   fifo_wr_en               FIFO write enable
//   fifo_wdata [WIDTH]       FIFO write data
// Modports:
//   master - the surrounding system (producers plus FIFO status)
//   slave  - the arbiter
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic [WIDTH-1:0]      fifo_wdata;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wdata
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_wdata
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter letting NREQ producers share one synchronous FIFO
// write port. A grant lasts for up to BURST beats; the granted producer's
// data is forwarded straight to the FIFO and fifo_full back-pressures it.
// Ports:
//   clk          system clock, rising edge
//   rstn         asynchronous active-low reset
//   bus          fifo_wr_arbiter_if.slave (producer handshake + FIFO write)
//   grant_valid  a producer currently holds the grant
//   grant_id     current (or most recent) granted producer
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  fifo_wr_arbiter_if.slave        bus,
  output logic                    grant_valid,
  output logic [$clog2(NREQ)-1:0] grant_id
);
  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(BURST) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] gid_q, gid_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IDW-1:0] pick, idx;
  logic           found;
  logic           any_valid, xfer, last_beat, rel;

  // Round-robin search starting one past the current holder. NREQ is a
  // power of two, so the IDW-bit add wraps naturally; k == NREQ lands back
  // on the holder, which therefore has the lowest priority.
  always_comb begin
    pick  = gid_q;
    idx   = gid_q;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = gid_q + IDW'(k);
      if (!found && bus.req_valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign grant_valid = (state_q == GRANT);
  assign grant_id    = gid_q;

  // Ready depends only on grant and full, so a stalled FIFO never releases
  // the holder and a producer may assert valid in response to ready.
  always_comb begin
    bus.req_ready = '0;
    if (grant_valid && !bus.fifo_full) bus.req_ready[gid_q] = 1'b1;
  end

  assign bus.fifo_wr_en = bus.req_valid[gid_q] & bus.req_ready[gid_q];

  always_comb begin
    bus.fifo_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gid_q == IDW'(i)) bus.fifo_wdata = bus.req_data[i*WIDTH +: WIDTH];
    end
  end

  assign any_valid = |bus.req_valid;
  assign xfer      = bus.fifo_wr_en;
  assign last_beat = (cnt_q == CW'(BURST - 1));
  // Release on valid drop or on the final beat of a burst; the new pick is
  // taken in the same cycle so handovers cost no bubble.
  assign rel       = !bus.req_valid[gid_q] || (xfer && last_beat);

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          state_d = GRANT;
          gid_d   = pick;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          if (any_valid) begin
            gid_d = pick;
            cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (xfer) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // grant_id resets to NREQ-1 so that producer 0 is searched first.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      gid_q   <= IDW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Drives two arbiters (BURST=4 and BURST=1, NREQ=4, WIDTH=8) from simple
// producer models: producer i offers cnt[i] beats starting at nxt[i] and
// advances when its beat is accepted. Expected FIFO writes are queued per
// arbiter and compared when fifo_wr_en is seen. A table of per-cycle
// vectors covers the cycle-level grant/ready behaviour.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus4 ();
  fifo_wr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus1 ();

  logic       gv4, gv1;
  logic [1:0] gid4, gid1;

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(4)) dut4 (
    .clk(clk), .rstn(rstn), .bus(bus4), .grant_valid(gv4), .grant_id(gid4)
  );

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(1)) dut1 (
    .clk(clk), .rstn(rstn), .bus(bus1), .grant_valid(gv1), .grant_id(gid1)
  );

  // producer model: index 0 feeds dut4, index 1 feeds dut1
  int         cnt [2][NREQ];
  logic [7:0] nxt [2][NREQ];
  logic       full [2];
  logic [3:0] acc [2];

  logic [7:0] q4[$];
  logic [7:0] q1[$];
  bit         sb_en;

  // outputs sampled mid-cycle by the last tick
  logic [3:0] s_ready [2];
  logic       s_wr [2];
  logic       s_gv [2];
  logic [1:0] s_gid [2];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] valid;
    logic       full;
    logic [3:0] ready;
    logic       wr;
    logic       gv;
    logic [1:0] gid;
  } vec_t;
  vec_t vt [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive();
    logic [3:0]  v0, v1;
    logic [31:0] d0, d1;
    for (int i = 0; i < NREQ; i++) begin
      v0[i] = (cnt[0][i] > 0);
      v1[i] = (cnt[1][i] > 0);
      d0[i*8 +: 8] = nxt[0][i];
      d1[i*8 +: 8] = nxt[1][i];
    end
    bus4.req_valid = v0;
    bus4.req_data  = d0;
    bus4.fifo_full = full[0];
    bus1.req_valid = v1;
    bus1.req_data  = d1;
    bus1.fifo_full = full[1];
  endtask

  task automatic mon();
    @(negedge clk);
    s_ready[0] = bus4.req_ready; s_wr[0] = bus4.fifo_wr_en; s_gv[0] = gv4; s_gid[0] = gid4;
    s_ready[1] = bus1.req_ready; s_wr[1] = bus1.fifo_wr_en; s_gv[1] = gv1; s_gid[1] = gid1;
    acc[0] = bus4.req_ready & bus4.req_valid;
    acc[1] = bus1.req_ready & bus1.req_valid;
    if (sb_en) begin
      if (bus4.fifo_wr_en === 1'b1) begin
        if (q4.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL dut4 unexpected write: got 0x%0h, required no write", bus4.fifo_wdata);
        end else check("dut4 wdata", 32'(bus4.fifo_wdata), 32'(q4.pop_front()));
      end
      if (bus1.fifo_wr_en === 1'b1) begin
        if (q1.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL dut1 unexpected write: got 0x%0h, required no write", bus1.fifo_wdata);
        end else check("dut1 wdata", 32'(bus1.fifo_wdata), 32'(q1.pop_front()));
      end
    end
  endtask

  task automatic upd();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NREQ; i++)
        if (acc[d][i]) begin
          cnt[d][i]--;
          nxt[d][i]++;
        end
  endtask

  task automatic tick();
    drive();
    mon();
    @(posedge clk); #1;
    upd();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      full[d] = 1'b0;
      acc[d]  = '0;
      for (int i = 0; i < NREQ; i++) begin
        cnt[d][i] = 0;
        nxt[d][i] = '0;
      end
    end
    q4.delete();
    q1.delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    check("reset gv4", gv4, 0);
    check("reset gid4", gid4, 3);
    check("reset wr4", bus4.fifo_wr_en, 0);
    check("reset ready4", bus4.req_ready, 0);
    check("reset gv1", gv1, 0);
    check("reset gid1", gid1, 3);
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // valid, full | ready, wr, gv, gid   (BURST=4 arbiter, cycle by cycle)
    vt[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd3};
    vt[1]  = '{4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd3};
    vt[2]  = '{4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1};
    vt[3]  = '{4'b0010, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd1};
    vt[4]  = '{4'b0011, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1};
    vt[5]  = '{4'b0001, 1'b0, 4'b0010, 1'b0, 1'b1, 2'd1};
    vt[6]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0};
    vt[7]  = '{4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1, 2'd0};
    vt[8]  = '{4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
    vt[9]  = '{4'b1000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd3};
    vt[10] = '{4'b1001, 1'b0, 4'b1000, 1'b1, 1'b1, 2'd3};
    vt[11] = '{4'b1001, 1'b0, 4'b1000, 1'b1, 1'b1, 2'd3};
    vt[12] = '{4'b1001, 1'b0, 4'b1000, 1'b1, 1'b1, 2'd3};
    vt[13] = '{4'b1001, 1'b0, 4'b1000, 1'b1, 1'b1, 2'd3};
    vt[14] = '{4'b1001, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0};
    vt[15] = '{4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1, 2'd0};
    vt[16] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};

    // ---- vector table
    do_reset();
    sb_en = 1'b0;
    for (int r = 0; r < 17; r++) begin
      for (int i = 0; i < NREQ; i++) cnt[0][i] = vt[r].valid[i] ? 100 : 0;
      full[0] = vt[r].full;
      tick();
      check($sformatf("vec%0d ready", r), s_ready[0], vt[r].ready);
      check($sformatf("vec%0d wr_en", r), s_wr[0], vt[r].wr);
      check($sformatf("vec%0d grant_valid", r), s_gv[0], vt[r].gv);
      check($sformatf("vec%0d grant_id", r), s_gid[0], vt[r].gid);
    end

    // ---- single requester 2, six beats: burst of 4 then no-bubble re-grant
    do_reset();
    sb_en = 1'b1;
    cnt[0][2] = 6; nxt[0][2] = 8'hA0;
    for (int k = 0; k < 6; k++) q4.push_back(8'(8'hA0 + k));
    tick(); check("single idle gv", s_gv[0], 0);
    tick(); check("single gv", s_gv[0], 1); check("single gid", s_gid[0], 2);
    repeat (3) tick();
    tick(); check("single regrant gid", s_gid[0], 2); check("single regrant no bubble", s_wr[0], 1);
    tick();
    tick(); check("single drop wr", s_wr[0], 0);
    tick(); check("single back to idle", s_gv[0], 0);
    check("single queue empty", q4.size(), 0);

    // ---- all four always valid: 4-beat bursts in order 0,1,2,3,0,...
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      cnt[0][i] = 8;
      nxt[0][i] = 8'(i * 16);
    end
    for (int rd = 0; rd < 2; rd++)
      for (int i = 0; i < NREQ; i++)
        for (int b = 0; b < 4; b++) q4.push_back(8'(i * 16 + rd * 4 + b));
    tick(); check("all4 first cycle idle", s_wr[0], 0);
    for (int c = 0; c < 32; c++) begin
      tick(); check($sformatf("all4 wr cycle %0d", c + 1), s_wr[0], 1);
    end
    tick(); check("all4 done wr", s_wr[0], 0);
    check("all4 queue empty", q4.size(), 0);

    // ---- fifo_full for 3 cycles after 2 beats; burst length must be kept
    do_reset();
    cnt[0][1] = 8; nxt[0][1] = 8'h50;
    cnt[0][2] = 4; nxt[0][2] = 8'h60;
    for (int k = 0; k < 4; k++) q4.push_back(8'(8'h50 + k));
    for (int k = 0; k < 4; k++) q4.push_back(8'(8'h60 + k));
    for (int k = 4; k < 8; k++) q4.push_back(8'(8'h50 + k));
    repeat (3) tick();
    full[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("full ready", s_ready[0], 0);
      check("full wr", s_wr[0], 0);
      check("full holds gid", s_gid[0], 1);
    end
    full[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick(); check("full resume wr", s_wr[0], 1);
    end
    tick(); check("full done wr", s_wr[0], 0);
    check("full queue empty", q4.size(), 0);

    // ---- requester 0 drops valid after 2 beats, requester 3 takes over
    do_reset();
    cnt[0][0] = 2; nxt[0][0] = 8'h70;
    cnt[0][3] = 3; nxt[0][3] = 8'h90;
    q4.push_back(8'h70); q4.push_back(8'h71);
    q4.push_back(8'h90); q4.push_back(8'h91); q4.push_back(8'h92);
    tick();
    tick(); check("drop first gid", s_gid[0], 0);
    tick();
    tick(); check("drop cycle wr", s_wr[0], 0); check("drop cycle gid", s_gid[0], 0);
    tick(); check("drop next gid", s_gid[0], 3); check("drop next wr", s_wr[0], 1);
    repeat (2) tick();
    tick(); check("drop done wr", s_wr[0], 0);
    check("drop queue empty", q4.size(), 0);

    // ---- asynchronous reset in the second cycle of a grant
    do_reset();
    cnt[0][0] = 8; nxt[0][0] = 8'hC0;
    cnt[0][2] = 2; nxt[0][2] = 8'hE0;
    q4.push_back(8'hC0);
    tick();
    tick();
    drive();
    #2;
    check("rstmid wr before", bus4.fifo_wr_en, 1);
    rstn = 1'b0;
    #1;
    check("rstmid wr falls", bus4.fifo_wr_en, 0);
    check("rstmid gv", gv4, 0);
    check("rstmid gid", gid4, 3);
    check("rstmid ready", bus4.req_ready, 0);
    mon();
    @(posedge clk); #1;
    upd();
    tick(); check("rstmid held gv", s_gv[0], 0); check("rstmid held gid", s_gid[0], 3);
    rstn = 1'b1;
    for (int k = 1; k < 5; k++) q4.push_back(8'(8'hC0 + k));
    q4.push_back(8'hE0); q4.push_back(8'hE1);
    for (int k = 5; k < 8; k++) q4.push_back(8'(8'hC0 + k));
    tick(); check("rstmid after idle", s_gv[0], 0);
    tick(); check("rstmid req0 first", s_gid[0], 0); check("rstmid req0 wr", s_wr[0], 1);
    repeat (9) tick();
    tick(); check("rstmid done wr", s_wr[0], 0);
    check("rstmid queue empty", q4.size(), 0);

    // ---- BURST=1: requesters 1 and 3 alternate every beat
    do_reset();
    cnt[1][1] = 4; nxt[1][1] = 8'hB0;
    cnt[1][3] = 4; nxt[1][3] = 8'hD0;
    for (int k = 0; k < 4; k++) begin
      q1.push_back(8'(8'hB0 + k));
      q1.push_back(8'(8'hD0 + k));
    end
    tick(); check("burst1 idle", s_gv[1], 0);
    for (int c = 0; c < 8; c++) begin
      tick();
      check("burst1 wr", s_wr[1], 1);
      check("burst1 gid", s_gid[1], (c % 2 == 0) ? 1 : 3);
    end
    tick(); check("burst1 done wr", s_wr[1], 0);
    check("burst1 queue empty", q1.size(), 0);
    check("dut4 queue empty at end", q4.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
